// File: rtl/calcu_pkg.sv
// calcu_pkg
// Shared definitions for the guided-filter coefficient stage (calcu_ab_pipe):
// the sequencer state type, default geometry/width constants and a helper
// that turns the frame geometry into a pixel count.
// Ports: none (package).
package calcu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } calcuStateT;

  localparam int DEF_IMG_W  = 300;
  localparam int DEF_IMG_H  = 210;
  localparam int DEF_DW     = 24;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_FRAC   = 7;
  localparam int DEF_RD_LAT = 1;

  // Number of pixels in one frame; used to size the address sweep.
  function automatic int pixelCount(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/calcu_ab_pipe_if.sv
// calcu_ab_pipe_if
// Bundles the controller handshake, the source-RAM read bus (var/mean) and
// the result-RAM write bus (A/B) of calcu_ab_pipe.
// Ports: none; parameters DW (data width) and ADDR_W (RAM address width).
//   master modport : the coefficient pipeline (drives busy/done/read/write).
//   slave modport  : the controller and RAMs around it.
interface calcu_ab_pipe_if
  import calcu_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              iStart;
  logic              iMode;
  logic [DW-1:0]     iEps;
  logic              oBusy;
  logic              oDone;
  logic              oRdEn;
  logic [ADDR_W-1:0] oRdAddr;
  logic [DW-1:0]     iVar;
  logic [DW-1:0]     iMean;
  logic [ADDR_W-1:0] oWrAddr;
  logic              oWrEnA;
  logic [DW-1:0]     oDataA;
  logic              oWrEnB;
  logic [DW-1:0]     oDataB;

  modport master (
    input  iStart, iMode, iEps, iVar, iMean,
    output oBusy, oDone, oRdEn, oRdAddr, oWrAddr, oWrEnA, oDataA, oWrEnB, oDataB
  );

  modport slave (
    output iStart, iMode, iEps, iVar, iMean,
    input  oBusy, oDone, oRdEn, oRdAddr, oWrAddr, oWrEnA, oDataA, oWrEnB, oDataB
  );

endinterface

// File: rtl/calcu_ab_pipe_ab_compute.sv
// ab_compute
// Two-stage registered arithmetic for one pixel per cycle:
//   stage 1: a = (var << FRAC) / (var + eps), or 1.0 when var + eps == 0
//   stage 2: b = mean - ((a * mean) >> FRAC), plus the write strobes/address
// Ports:
//   iCLK, iRST_N     clock, synchronous active-low reset
//   inValid, inAddr  pixel valid/address aligned with inVar/inMean
//   inVar, inMean    source data
//   eps, mode        frame-constant regularisation term and write mode
//   s1Valid          stage-1 occupancy, used by the sequencer to detect drain
//   wrEnA/wrEnB      result RAM strobes, wrAddr shared address
//   dataA/dataB      coefficients (a zero-extended)
module ab_compute
  import calcu_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int FRAC   = DEF_FRAC
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              inValid,
  input  logic [ADDR_W-1:0] inAddr,
  input  logic [DW-1:0]     inVar,
  input  logic [DW-1:0]     inMean,
  input  logic [DW-1:0]     eps,
  input  logic              mode,
  output logic              s1Valid,
  output logic              wrEnA,
  output logic              wrEnB,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DW-1:0]     dataA,
  output logic [DW-1:0]     dataB
);

  // a never exceeds 1 << FRAC, so FRAC+1 bits hold it exactly.
  localparam int AW = FRAC + 1;
  localparam int QW = DW + FRAC;
  localparam int PW = DW + FRAC + 1;
  localparam logic [AW-1:0] A_ONE = AW'(32'd1 << FRAC);

  logic [QW-1:0]     num;
  logic [QW-1:0]     den;
  logic [AW-1:0]     aNext;
  logic [ADDR_W-1:0] s1Addr;
  logic [AW-1:0]     s1A;
  logic [DW-1:0]     s1Mean;
  logic [DW-1:0]     bSub;
  logic [DW-1:0]     bVal;

  // The denominator is computed at full quotient width so var + eps cannot
  // wrap; a zero denominator means "no variance, no regularisation" and a
  // saturates to 1.0.
  always_comb begin
    num = {inVar, {FRAC{1'b0}}};
    den = QW'(inVar) + QW'(eps);
    if (den == '0) begin
      aNext = A_ONE;
    end else begin
      aNext = AW'(num / den);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      s1Valid <= 1'b0;
      s1Addr  <= '0;
      s1A     <= '0;
      s1Mean  <= '0;
    end else begin
      s1Valid <= inValid;
      s1Addr  <= inAddr;
      s1A     <= aNext;
      s1Mean  <= inMean;
    end
  end

  // Since a <= 1.0, (a * mean) >> FRAC <= mean, so the subtraction never
  // underflows.
  always_comb begin
    bSub = DW'((PW'(s1A) * PW'(s1Mean)) >> FRAC);
    bVal = s1Mean - bSub;
  end

  // Data outputs are forced to zero outside a write so idle buses are quiet
  // and mode 0 keeps the B data at zero.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      wrEnA  <= 1'b0;
      wrEnB  <= 1'b0;
      wrAddr <= '0;
      dataA  <= '0;
      dataB  <= '0;
    end else begin
      wrEnA  <= s1Valid;
      wrEnB  <= s1Valid & mode;
      wrAddr <= s1Addr;
      dataA  <= s1Valid ? DW'(s1A) : '0;
      dataB  <= (s1Valid & mode) ? bVal : '0;
    end
  end

endmodule

// File: rtl/calcu_ab_pipe.sv
// calcu_ab_pipe
// Streams one frame of var/mean words from the source RAMs, computes the
// guided-filter coefficients a (and optionally b) and writes them to the A/B
// result RAMs at one pixel per cycle. Sequenced by iStart / oDone.
// Ports:
//   iCLK, iRST_N  clock, synchronous active-low reset
//   pipeBus       calcu_ab_pipe_if.master: start/mode/eps, busy/done,
//                 source read bus (oRdEn, oRdAddr, iVar, iMean) and
//                 result write bus (oWrAddr, oWrEnA, oDataA, oWrEnB, oDataB)
module calcu_ab_pipe
  import calcu_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int DW     = DEF_DW,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int FRAC   = DEF_FRAC,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input logic             iCLK,
  input logic             iRST_N,
  calcu_ab_pipe_if.master pipeBus
);

  localparam int N = pixelCount(IMG_W, IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  calcuStateT        state;
  calcuStateT        stateNext;
  logic [ADDR_W-1:0] addrCnt;
  logic [DW-1:0]     epsReg;
  logic              modeReg;
  logic [RD_LAT-1:0] vPipe;
  logic [ADDR_W-1:0] aPipe [RD_LAT];
  logic              s1Valid;
  logic              pipeEmpty;

  // Once reads stop, the last pixel still has to cross the latency line and
  // stage 1; when both are empty the final write is sitting in stage 2, so
  // DONE lands exactly one cycle after it.
  assign pipeEmpty = (vPipe == '0) && !s1Valid;

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext        = state;
    pipeBus.oBusy    = 1'b0;
    pipeBus.oDone    = 1'b0;
    pipeBus.oRdEn    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pipeBus.iStart) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        pipeBus.oBusy = 1'b1;
        pipeBus.oRdEn = 1'b1;
        if (addrCnt == LAST_ADDR) begin
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        pipeBus.oBusy = 1'b1;
        if (pipeEmpty) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        pipeBus.oDone = 1'b1;
        stateNext     = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // The read address stops at the last pixel and is only rewound outside a
  // frame, so it never wraps or leaves the frame.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      addrCnt <= '0;
    end else if (state == RUN) begin
      if (addrCnt != LAST_ADDR) begin
        addrCnt <= addrCnt + 1'b1;
      end
    end else if (state != DRAIN) begin
      addrCnt <= '0;
    end
  end

  assign pipeBus.oRdAddr = addrCnt;

  // eps and mode are frozen for the whole frame at the accepted start.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      epsReg  <= '0;
      modeReg <= 1'b0;
    end else if (state == IDLE && pipeBus.iStart) begin
      epsReg  <= pipeBus.iEps;
      modeReg <= pipeBus.iMode;
    end
  end

  // Read-latency alignment: valid is cleared on reset so an aborted frame
  // leaves nothing behind; the address copies only matter while valid.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      vPipe <= '0;
    end else begin
      vPipe[0] <= pipeBus.oRdEn;
      for (int i = 1; i < RD_LAT; i++) begin
        vPipe[i] <= vPipe[i-1];
      end
    end
  end

  always_ff @(posedge iCLK) begin
    aPipe[0] <= addrCnt;
    for (int i = 1; i < RD_LAT; i++) begin
      aPipe[i] <= aPipe[i-1];
    end
  end

  ab_compute #(
    .DW     (DW),
    .ADDR_W (ADDR_W),
    .FRAC   (FRAC)
  ) uCompute (
    .iCLK    (iCLK),
    .iRST_N  (iRST_N),
    .inValid (vPipe[RD_LAT-1]),
    .inAddr  (aPipe[RD_LAT-1]),
    .inVar   (pipeBus.iVar),
    .inMean  (pipeBus.iMean),
    .eps     (epsReg),
    .mode    (modeReg),
    .s1Valid (s1Valid),
    .wrEnA   (pipeBus.oWrEnA),
    .wrEnB   (pipeBus.oWrEnB),
    .wrAddr  (pipeBus.oWrAddr),
    .dataA   (pipeBus.oDataA),
    .dataB   (pipeBus.oDataB)
  );

endmodule

// File: tb/tb_calcu_ab_pipe.sv
// tb_calcu_ab_pipe
// Runs two copies of calcu_ab_pipe (read latency 1 and 3) on a 4x2 frame
// from shared var/mean memories. Constant-value frames come from a table of
// hand-computed coefficients; random frames are predicted by a plain
// arithmetic model of the coefficient formulas. Per cycle, busy/done/read
// and write timing are predicted from the frame position alone.
// Ports: none.
module tb_calcu_ab_pipe;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int N      = IMG_W * IMG_H;
  localparam int DW     = 24;
  localparam int ADDR_W = 4;
  localparam int FRAC   = 7;
  localparam int FRAME_CYCLES = N + 3 + 3 + 2;

  typedef struct {
    logic              busy;
    logic              done;
    logic              rdEn;
    logic              wrEnA;
    logic              wrEnB;
    logic [ADDR_W-1:0] rdAddr;
    logic [ADDR_W-1:0] wrAddr;
    logic [DW-1:0]     dataA;
    logic [DW-1:0]     dataB;
  } snapT;

  typedef struct {
    logic [DW-1:0] v;
    logic [DW-1:0] m;
    logic [DW-1:0] e;
    bit            mode;
    int            restartAt;
    longint        a;
    longint        b;
  } vecT;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;
  always #5 iCLK = ~iCLK;

  int compared = 0;
  int mismatched = 0;
  int lats [2] = '{1, 3};

  logic [DW-1:0] varMem  [16];
  logic [DW-1:0] meanMem [16];
  longint expA [N];
  longint expB [N];
  vecT vecs [7];

  calcu_ab_pipe_if #(.DW(DW), .ADDR_W(ADDR_W)) bus1 ();
  calcu_ab_pipe_if #(.DW(DW), .ADDR_W(ADDR_W)) bus3 ();

  calcu_ab_pipe #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .ADDR_W(ADDR_W), .FRAC(FRAC), .RD_LAT(1)
  ) dut1 (
    .iCLK(iCLK), .iRST_N(iRST_N), .pipeBus(bus1)
  );

  calcu_ab_pipe #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .ADDR_W(ADDR_W), .FRAC(FRAC), .RD_LAT(3)
  ) dut3 (
    .iCLK(iCLK), .iRST_N(iRST_N), .pipeBus(bus3)
  );

  // Source RAM with one cycle of read latency.
  always @(posedge iCLK) begin
    bus1.iVar  <= varMem[bus1.oRdAddr];
    bus1.iMean <= meanMem[bus1.oRdAddr];
  end

  // Source RAM with three cycles of read latency.
  logic [DW-1:0] v3 [3];
  logic [DW-1:0] m3 [3];
  always @(posedge iCLK) begin
    v3[0] <= varMem[bus3.oRdAddr];
    m3[0] <= meanMem[bus3.oRdAddr];
    v3[1] <= v3[0];
    m3[1] <= m3[0];
    v3[2] <= v3[1];
    m3[2] <= m3[1];
  end
  assign bus3.iVar  = v3[2];
  assign bus3.iMean = m3[2];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // a = var/(var+eps) in FRAC fixed point, b = mean*(1-a), both truncated.
  function automatic void refModel(input longint v, input longint m, input longint e,
                                   output longint a, output longint b);
    if (v + e == 0) a = 128;
    else a = (v * 128) / (v + e);
    b = m - (a * m) / 128;
  endfunction

  function automatic snapT sample(input int d);
    snapT s;
    if (d == 0) begin
      s.busy = bus1.oBusy; s.done = bus1.oDone; s.rdEn = bus1.oRdEn;
      s.wrEnA = bus1.oWrEnA; s.wrEnB = bus1.oWrEnB; s.rdAddr = bus1.oRdAddr;
      s.wrAddr = bus1.oWrAddr; s.dataA = bus1.oDataA; s.dataB = bus1.oDataB;
    end else begin
      s.busy = bus3.oBusy; s.done = bus3.oDone; s.rdEn = bus3.oRdEn;
      s.wrEnA = bus3.oWrEnA; s.wrEnB = bus3.oWrEnB; s.rdAddr = bus3.oRdAddr;
      s.wrAddr = bus3.oWrAddr; s.dataA = bus3.oDataA; s.dataB = bus3.oDataB;
    end
    return s;
  endfunction

  task automatic applyStimulus(input bit start, input bit mode, input logic [DW-1:0] eps);
    bus1.iStart = start; bus1.iMode = mode; bus1.iEps = eps;
    bus3.iStart = start; bus3.iMode = mode; bus3.iEps = eps;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Control bits packed as {busy, done, rdEn, wrEnA, wrEnB}.
  task automatic checkQuiet(input string tag);
    snapT s;
    for (int d = 0; d < 2; d++) begin
      s = sample(d);
      checkOutput($sformatf("L%0d %s ctrl", lats[d], tag),
                  {s.busy, s.done, s.rdEn, s.wrEnA, s.wrEnB}, 64'd0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    snapT s;
    checkQuiet(tag);
    for (int d = 0; d < 2; d++) begin
      s = sample(d);
      checkOutput($sformatf("L%0d %s rdAddr", lats[d], tag), s.rdAddr, 0);
      checkOutput($sformatf("L%0d %s wrAddr", lats[d], tag), s.wrAddr, 0);
      checkOutput($sformatf("L%0d %s dataA", lats[d], tag), s.dataA, 0);
      checkOutput($sformatf("L%0d %s dataB", lats[d], tag), s.dataB, 0);
    end
  endtask

  // Cycle c counts from the start-sample edge (c = 0).
  task automatic checkCycle(input int c, input bit mode);
    snapT s;
    int l, k;
    bit busyE, doneE, rdEnE, wrAE, wrBE;
    for (int d = 0; d < 2; d++) begin
      l = lats[d];
      s = sample(d);
      busyE = (c >= 1) && (c <= N + l + 2);
      doneE = (c == N + l + 3);
      rdEnE = (c >= 1) && (c <= N);
      wrAE  = (c >= l + 3) && (c <= N + l + 2);
      wrBE  = wrAE && mode;
      k = c - l - 3;
      checkOutput($sformatf("L%0d c%0d ctrl", l, c),
                  {s.busy, s.done, s.rdEn, s.wrEnA, s.wrEnB},
                  {busyE, doneE, rdEnE, wrAE, wrBE});
      if (rdEnE) checkOutput($sformatf("L%0d c%0d rdAddr", l, c), s.rdAddr, c - 1);
      if (wrAE) begin
        checkOutput($sformatf("L%0d c%0d wrAddr", l, c), s.wrAddr, k);
        checkOutput($sformatf("L%0d c%0d dataA", l, c), s.dataA, expA[k]);
      end
      if (wrBE) checkOutput($sformatf("L%0d c%0d dataB", l, c), s.dataB, expB[k]);
      if (!mode) checkOutput($sformatf("L%0d c%0d dataB0", l, c), s.dataB, 0);
    end
  endtask

  // One full frame; iEps/iMode are scrambled after the start to show they
  // are ignored, and an optional extra start pulse lands mid-frame.
  task automatic runFrame(input bit mode, input logic [DW-1:0] eps, input int restartAt);
    @(negedge iCLK);
    applyStimulus(1'b1, mode, eps);
    @(posedge iCLK);
    for (int c = 1; c <= FRAME_CYCLES; c++) begin
      @(negedge iCLK);
      checkCycle(c, mode);
      applyStimulus(c == restartAt, 1'($urandom_range(0, 1)), DW'($urandom));
    end
  endtask

  task automatic fillConst(input logic [DW-1:0] v, input logic [DW-1:0] m);
    for (int k = 0; k < 16; k++) begin
      varMem[k] = v;
      meanMem[k] = m;
    end
  endtask

  initial begin
    vecs[0] = '{24'd100, 24'd64, 24'd28, 1'b1, -1, 100, 14};
    vecs[1] = '{24'd0, 24'd50, 24'd0, 1'b1, -1, 128, 0};
    vecs[2] = '{24'd1000, 24'd200, 24'd0, 1'b1, -1, 128, 0};
    vecs[3] = '{24'd10, 24'd200, 24'd1000, 1'b1, -1, 1, 199};
    vecs[4] = '{24'd100, 24'd64, 24'd28, 1'b0, 5, 100, 0};
    vecs[5] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b1, -1, 64, 8388608};
    vecs[6] = '{24'd0, 24'd77, 24'd5, 1'b1, -1, 0, 77};

    applyStimulus(1'b0, 1'b0, '0);
    fillConst('0, '0);
    iRST_N = 1'b0;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    checkAllZero("reset");
    iRST_N = 1'b1;
    @(negedge iCLK);
    checkQuiet("idle");

    $display("[TB] table-driven frames");
    for (int i = 0; i < 7; i++) begin
      fillConst(vecs[i].v, vecs[i].m);
      for (int k = 0; k < N; k++) begin
        expA[k] = vecs[i].a;
        expB[k] = vecs[i].b;
      end
      runFrame(vecs[i].mode, vecs[i].e, vecs[i].restartAt);
    end

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      logic [DW-1:0] eps;
      bit mode;
      eps  = (f == 0) ? '0 : ((f % 2) ? DW'($urandom_range(0, 300)) : DW'($urandom));
      mode = (f < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int k = 0; k < N; k++) begin
        varMem[k]  = (f % 2) ? DW'($urandom_range(0, 255)) : DW'($urandom);
        meanMem[k] = DW'($urandom);
      end
      if (f == 0) varMem[3] = '0;
      for (int k = 0; k < N; k++) refModel(varMem[k], meanMem[k], eps, expA[k], expB[k]);
      runFrame(mode, eps, -1);
    end

    $display("[TB] reset mid-frame");
    fillConst(24'd100, 24'd64);
    @(negedge iCLK);
    applyStimulus(1'b1, 1'b1, 24'd28);
    @(posedge iCLK);
    for (int c = 1; c <= 6; c++) begin
      @(negedge iCLK);
      applyStimulus(1'b0, 1'b1, 24'd28);
      if (c == 6) iRST_N = 1'b0;
    end
    @(negedge iCLK);
    checkAllZero("midreset");
    iRST_N = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge iCLK);
      checkQuiet($sformatf("postreset%0d", c));
    end
    for (int k = 0; k < N; k++) begin
      expA[k] = 100;
      expB[k] = 14;
    end
    runFrame(1'b1, 24'd28, -1);

    $display("[TB] start held high");
    @(negedge iCLK);
    applyStimulus(1'b1, 1'b1, 24'd28);
    @(posedge iCLK);
    for (int c = 1; c <= FRAME_CYCLES; c++) begin
      @(negedge iCLK);
      for (int d = 0; d < 2; d++) begin
        snapT s;
        s = sample(d);
        if (c == N + lats[d] + 4)
          checkOutput($sformatf("L%0d held c%0d ctrl", lats[d], c), {s.busy, s.done, s.rdEn}, 3'b000);
        if (c == N + lats[d] + 5) begin
          checkOutput($sformatf("L%0d held c%0d ctrl", lats[d], c), {s.busy, s.done, s.rdEn}, 3'b101);
          checkOutput($sformatf("L%0d held c%0d rdAddr", lats[d], c), s.rdAddr, 0);
        end
      end
    end
    @(negedge iCLK);
    applyStimulus(1'b0, 1'b1, 24'd28);
    repeat (20) @(negedge iCLK);
    checkQuiet("heldend");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
